// File: rtl/nibble_packer.sv
// nibble_packer: packs a stream of 4-bit nibbles into 16-bit words with flush of partial words.
// A full word can wait in the accumulator while the output register is stalled.
module nibble_packer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [3:0]  inData,
    output logic        inReady,
    input  logic        flush,
    output logic        outValid,
    output logic [15:0] outData,
    output logic [2:0]  outCount,
    input  logic        outReady
);
    logic [15:0] acc_q, acc_d, acc_a, out_data_q, out_data_d;
    logic [2:0]  cnt_q, cnt_d, cnt_a, out_count_q, out_count_d;
    logic        pend_q, pend_d, out_valid_q, out_valid_d;
    logic        accept, out_free, want;
    logic [3:0]  sh;
    always_comb begin
        inReady     = (cnt_q != 3'd4) && !pend_q;
        accept      = inValid && inReady;
        out_free    = !out_valid_q || outReady;
        // Unused slots stay zero, so OR-ing the new nibble in yields zero padding for free
        sh          = MSB_FIRST ? {~cnt_q[1:0], 2'b00} : {cnt_q[1:0], 2'b00};
        acc_a       = accept ? (acc_q | ({12'b0, inData} << sh)) : acc_q;
        cnt_a       = cnt_q + {2'b00, accept};
        want        = (cnt_a == 3'd4) || ((flush || pend_q) && (cnt_a != 3'd0));
        acc_d       = acc_a;
        cnt_d       = cnt_a;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (want && out_free) begin
            acc_d       = '0;
            cnt_d       = '0;
            pend_d      = 1'b0;
            out_data_d  = acc_a;
            out_count_d = cnt_a;
            out_valid_d = 1'b1;
        end else begin
            pend_d = pend_q || (want && (cnt_a != 3'd4));
            if (out_valid_q && outReady) begin
                out_data_d  = '0;
                out_count_d = '0;
                out_valid_d = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outCount = out_count_q;
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed bench for both nibble orders against a queue-based model.
module tb_nibble_packer;
    logic        clk = 1'b0;
    logic        reset, inValid, flush, outReady;
    logic [3:0]  inData;
    logic        m_ir, m_ov, l_ir, l_ov;
    logic [15:0] m_od, l_od;
    logic [2:0]  m_oc, l_oc;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [3:0]  q[$];
    logic [3:0]  o[$];
    bit          pend, ov, started;
    always #5 clk = ~clk;
    nibble_packer #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .inValid(inValid), .inData(inData), .inReady(m_ir),
        .flush(flush), .outValid(m_ov), .outData(m_od), .outCount(m_oc), .outReady(outReady)
    );
    nibble_packer #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .inValid(inValid), .inData(inData), .inReady(l_ir),
        .flush(flush), .outValid(l_ov), .outData(l_od), .outCount(l_oc), .outReady(outReady)
    );
    function automatic logic [15:0] pack(input logic [3:0] n[$], input bit msb);
        logic [15:0] w = '0;
        for (int i = 0; i < n.size(); i++)
            if (msb) w[15-4*i -: 4] = n[i];
            else w[4*i +: 4] = n[i];
        return w;
    endfunction
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a word is a list of accepted nibbles; bit placement is decided only when packing
    always @(posedge clk) begin
        bit rdy, free, want;
        if (reset) begin
            q.delete();
            o.delete();
            pend = 0;
            ov = 0;
        end else begin
            rdy  = (q.size() != 4) && !pend;
            free = !ov || outReady;
            if (inValid && rdy) q.push_back(inData);
            want = (q.size() == 4) || ((flush || pend) && q.size() != 0);
            if (want && free) begin
                o = q;
                q.delete();
                ov = 1;
                pend = 0;
            end else begin
                if (want && q.size() != 4) pend = 1;
                if (ov && outReady) begin
                    ov = 0;
                    o.delete();
                end
            end
        end
        started = 1;
    end
    always @(negedge clk) if (started) begin
        chk("m_valid", 16'(m_ov), 16'(ov));
        chk("m_data", m_od, pack(o, 1'b1));
        chk("m_count", 16'(m_oc), 16'(o.size()));
        chk("m_ready", 16'(m_ir), 16'((q.size() != 4) && !pend));
        chk("l_valid", 16'(l_ov), 16'(ov));
        chk("l_data", l_od, pack(o, 1'b0));
        chk("l_count", 16'(l_oc), 16'(o.size()));
        chk("l_ready", 16'(l_ir), 16'((q.size() != 4) && !pend));
    end
    task automatic cyc(input bit v, input logic [3:0] d, input bit f);
        inValid = v;
        inData  = d;
        flush   = f;
        @(negedge clk);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1; inValid = 0; inData = 0; flush = 0; outReady = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("lit_rst_valid", 16'(m_ov), 16'h0);
        chk("lit_rst_data", m_od, 16'h0);
        chk("lit_rst_count", 16'(m_oc), 16'h0);
        chk("lit_rst_ready", 16'(m_ir), 16'h1);
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0);
        chk("lit_1234", m_od, 16'h1234);
        chk("lit_1234_cnt", 16'(m_oc), 16'h4);
        chk("lit_1234_valid", 16'(m_ov), 16'h1);
        chk("lit_4321", l_od, 16'h4321);
        chk("lit_4321_cnt", 16'(l_oc), 16'h4);
        cyc(0, 0, 0);
        chk("lit_1234_onecycle", 16'(m_ov), 16'h0);
        cyc(0, 0, 1);
        chk("lit_emptyflush", 16'(m_ov), 16'h0);
        outReady = 0;
        for (int i = 1; i <= 8; i++) cyc(1, 4'(i), 0);
        chk("lit_stall_data", m_od, 16'h1234);
        chk("lit_stall_ready", 16'(m_ir), 16'h0);
        cyc(1, 4'hF, 0);
        chk("lit_stall_hold", m_od, 16'h1234);
        outReady = 1;
        cyc(0, 0, 0);
        chk("lit_5678", m_od, 16'h5678);
        chk("lit_5678_ready", 16'(m_ir), 16'h1);
        cyc(0, 0, 0);
        chk("lit_5678_drain", 16'(m_ov), 16'h0);
        cyc(1, 4'h9, 0);
        cyc(1, 4'hC, 0);
        cyc(0, 0, 1);
        chk("lit_9C00", m_od, 16'h9C00);
        chk("lit_9C00_cnt", 16'(m_oc), 16'h2);
        cyc(0, 0, 0);
        cyc(1, 4'h9, 0);
        cyc(1, 4'hC, 0);
        cyc(1, 4'h5, 1);
        chk("lit_9C50", m_od, 16'h9C50);
        chk("lit_9C50_cnt", 16'(m_oc), 16'h3);
        chk("lit_05C9", l_od, 16'h05C9);
        cyc(0, 0, 0);
        outReady = 0;
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0);
        cyc(1, 4'hA, 0);
        cyc(0, 0, 1);
        chk("lit_pend_ready", 16'(m_ir), 16'h0);
        chk("lit_pend_held", m_od, 16'h1234);
        cyc(0, 0, 1);
        chk("lit_pend_absorb", m_od, 16'h1234);
        outReady = 1;
        cyc(0, 0, 0);
        chk("lit_A000", m_od, 16'hA000);
        chk("lit_A000_cnt", 16'(m_oc), 16'h1);
        chk("lit_000A", l_od, 16'h000A);
        chk("lit_A000_ready", 16'(m_ir), 16'h1);
        cyc(0, 0, 0);
        cyc(1, 4'h1, 0);
        cyc(1, 4'h2, 0);
        reset = 1;
        cyc(0, 0, 0);
        reset = 0;
        for (int i = 3; i <= 6; i++) cyc(1, 4'(i), 0);
        chk("lit_3456", m_od, 16'h3456);
        chk("lit_3456_cnt", 16'(m_oc), 16'h4);
        cyc(0, 0, 0);
        outReady = 0;
        for (int i = 1; i <= 5; i++) cyc(1, 4'(i), 0);
        reset = 1;
        cyc(1, 4'h7, 1);
        reset = 0;
        chk("lit_rst_stall_valid", 16'(m_ov), 16'h0);
        chk("lit_rst_stall_data", m_od, 16'h0);
        outReady = 1;
        cyc(0, 0, 1);
        chk("lit_rst_stall_flush", 16'(m_ov), 16'h0);
        cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
